fifo_pop_stage: RTL

Downstream drain stage for the circular-pointer FIFO. It pops words from the FIFO's show-ahead head, holds them in a two-entry registered buffer, and presents them on a valid/ready stream to the consumer. It sustains one word per cycle under continuous `out_ready` and never drives a pop while the FIFO is empty. It also provides a synchronous flush and a transfer counter for scoreboard cross-checks.

---
 rtl/fifo_pop_stage_if.sv | 25 ++
 rtl/fifo_pop_stage.sv | 71 +++++++
 2 files changed

// File: rtl/fifo_pop_stage_if.sv
// Handshake bundle between the FIFO head, the pop stage and the downstream consumer.
// The master view belongs to the pop stage; the slave view is the surrounding environment.
interface fifo_pop_stage_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [15:0]      xfer_count;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_pop, out_valid, out_data, occupancy, xfer_count
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_pop, out_valid, out_data, occupancy, xfer_count
    );
endinterface

// File: rtl/fifo_pop_stage.sv
// Drain stage: pops a show-ahead FIFO into a two-entry registered skid buffer and
// presents the head on a valid/ready stream, with flush and a handshake counter.
module fifo_pop_stage #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_pop_stage_if.master       bus
);
    localparam int DEPTH = 2;

    logic [DEPTH-1:0][WIDTH-1:0] slot_reg;
    logic [DEPTH-1:0][WIDTH-1:0] shift_src;
    logic [1:0]                  occ_reg;
    logic [1:0]                  occ_next;
    logic [1:0]                  wr_idx;
    logic [15:0]                 xfer_reg;
    logic [15:0]                 xfer_next;
    logic                        deq;
    logic                        pop;
    logic                        shift;

    always_comb begin
        deq       = (occ_reg != 2'd0) && bus.out_ready;
        // A full buffer may only pop when the head leaves in the same cycle.
        pop       = !rst && !bus.flush && !bus.fifo_empty &&
                    ((occ_reg < 2'd2) || bus.out_ready);
        shift     = deq && (occ_reg == 2'd2);
        wr_idx    = occ_reg - {1'b0, deq};
        occ_next  = bus.flush ? 2'd0 : (occ_reg + {1'b0, pop} - {1'b0, deq});
        xfer_next = xfer_reg + {15'd0, deq};
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi < DEPTH - 1) begin : g_shift
                assign shift_src[gi] = slot_reg[gi+1];
            end else begin : g_last
                assign shift_src[gi] = slot_reg[gi];
            end

            // Incoming word lands at the first free index after this cycle's dequeue.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg[gi] <= '0;
                end else if (pop && (wr_idx == 2'(gi))) begin
                    slot_reg[gi] <= bus.fifo_data;
                end else if (shift) begin
                    slot_reg[gi] <= shift_src[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg  <= 2'd0;
            xfer_reg <= 16'd0;
        end else begin
            occ_reg  <= occ_next;
            xfer_reg <= xfer_next;
        end
    end

    assign bus.fifo_pop   = pop;
    assign bus.out_valid  = (occ_reg != 2'd0);
    assign bus.out_data   = slot_reg[0];
    assign bus.occupancy  = occ_reg;
    assign bus.xfer_count = xfer_reg;
endmodule
